// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg: shared constants, channel-status builder and subpacket packer
// Revision: 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

   localparam logic [7:0] PKT_TYPE_ACR          = 8'd1;
   localparam logic [7:0] PKT_TYPE_AUDIO_SAMPLE = 8'd2;

   localparam int CS_BITS          = 192;
   localparam int CS_CATEGORY_W    = 8;
   localparam int CS_CHANNEL_W     = 4;
   localparam int CS_FS_W          = 4;
   localparam int CS_WORD_LENGTH_W = 4;
   localparam int IEC_FRAMES       = 192;

   typedef struct packed {
      logic                        sample_word_type;
      logic                        copyright_asserted;
      logic [CS_CATEGORY_W-1:0]    category_code;
      logic [CS_FS_W-1:0]          sampling_frequency;
      logic [CS_WORD_LENGTH_W-1:0] word_length;
   } cs_params_t;

   // Consumer-format status word; bit k is transmitted in IEC frame k.
   function automatic logic [CS_BITS-1:0] build_channel_status(input cs_params_t p,
                                                                input int unsigned channel);
      logic [CS_BITS-1:0] cs;
      cs        = '0;
      cs[1]     = p.sample_word_type;
      cs[2]     = p.copyright_asserted;
      cs[15:8]  = p.category_code;
      cs[23:20] = CS_CHANNEL_W'(channel + 1);
      cs[27:24] = p.sampling_frequency;
      cs[35:32] = p.word_length;
      return cs;
   endfunction

   function automatic logic [55:0] pack_subpacket(input logic [23:0] even_sample,
                                                  input logic [23:0] odd_sample,
                                                  input logic even_v, even_u, even_c,
                                                  input logic odd_v, odd_u, odd_c);
      logic even_p, odd_p;
      even_p = ^{even_sample, even_v, even_u, even_c};
      odd_p  = ^{odd_sample, odd_v, odd_u, odd_c};
      return {odd_p, odd_c, odd_u, odd_v, even_p, even_c, even_u, even_v, odd_sample, even_sample};
   endfunction

   function automatic logic [7:0] frame_index_add(input logic [7:0] base, input logic [2:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {6'd0, inc};
      return (sum >= 9'(IEC_FRAMES)) ? 8'(sum - 9'(IEC_FRAMES)) : sum[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/audio_frame_fifo.sv
// ============================================================================
// audio_frame_fifo: single-push, pop-up-to-4 FIFO exposing its oldest entries
// Revision: 1.0
// ============================================================================
`default_nettype none

module audio_frame_fifo #(
   parameter int WIDTH = 52,
   parameter int DEPTH = 16,
   parameter int TAPS  = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic [2:0]                   pop_count,
   output logic                         ready,
   output logic [$clog2(DEPTH):0]       level,
   output logic [TAPS-1:0][WIDTH-1:0]   taps
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_next;

   assign level_next = level + LW'(push) - LW'(pop_count);

   generate
      for (genvar t = 0; t < TAPS; t++) begin : g_tap
         assign taps[t] = mem[rd_ptr + AW'(t)];
      end
   endgenerate

   // Ready is registered so it stays low through reset and rises one cycle after release.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ready  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr + AW'(pop_count);
         level  <= level_next;
         ready  <= (level_next < LW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/audio_sample_packet_multichannel.sv
// ============================================================================
// audio_sample_packet_multichannel: buffered HDMI audio sample packet builder
// Revision: 1.0
// ============================================================================
`default_nettype none

module audio_sample_packet_multichannel
   import audio_pkg::*;
#(
   parameter int         CHANNELS           = 2,
   parameter int         SAMPLE_WIDTH       = 24,
   parameter int         FIFO_DEPTH         = 16,
   parameter logic       SAMPLE_WORD_TYPE   = 1'b0,
   parameter logic       COPYRIGHT_ASSERTED = 1'b1,
   parameter logic [7:0] CATEGORY_CODE      = 8'h00,
   parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0000,
   parameter logic [3:0] WORD_LENGTH        = 4'b1011
) (
   input  logic                                   clk_packet,
   input  logic                                   reset_n,
   input  logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0]  audio_sample_word,
   input  logic [CHANNELS-1:0]                    valid_bit,
   input  logic [CHANNELS-1:0]                    user_data_bit,
   input  logic                                   audio_valid,
   output logic                                   audio_ready,
   input  logic                                   packet_request,
   output logic                                   packet_valid,
   output logic [23:0]                            header,
   output logic [3:0][55:0]                       sub,
   output logic [$clog2(FIFO_DEPTH):0]            fifo_level
);

   localparam logic LAYOUT  = logic'(CHANNELS > 2);
   localparam int   SLOT_W  = SAMPLE_WIDTH + 2;
   localparam int   ENTRY_W = CHANNELS * SLOT_W;
   localparam int   TAPS    = (CHANNELS > 2) ? 1 : 4;
   localparam int   LW      = $clog2(FIFO_DEPTH) + 1;

   localparam cs_params_t CS_PARAMS = '{
      sample_word_type:   SAMPLE_WORD_TYPE,
      copyright_asserted: COPYRIGHT_ASSERTED,
      category_code:      CATEGORY_CODE,
      sampling_frequency: SAMPLING_FREQUENCY,
      word_length:        WORD_LENGTH
   };

   logic                           push;
   logic [ENTRY_W-1:0]             push_entry;
   logic [2:0]                     pop_avail;
   logic [2:0]                     pop_count;
   logic [TAPS-1:0][ENTRY_W-1:0]   taps;
   logic [7:0]                     frame_counter;
   logic [7:0]                     frame_counter_next;
   logic [CS_BITS-1:0]             channel_status [CHANNELS];
   logic [3:0]                     present;
   logic [3:0]                     b_flags;
   logic [3:0][55:0]               sub_next;

   function automatic logic [23:0] justify(input logic [SAMPLE_WIDTH-1:0] s);
      return 24'(s) << (24 - SAMPLE_WIDTH);
   endfunction

   // Entry slot per channel is {U, V, sample}.
   function automatic logic [55:0] build_sub(input logic [ENTRY_W-1:0] e, input int even_ch,
                                             input logic even_c, input logic odd_c);
      int eb, ob;
      eb = even_ch * SLOT_W;
      ob = eb + SLOT_W;
      return pack_subpacket(justify(e[eb +: SAMPLE_WIDTH]), justify(e[ob +: SAMPLE_WIDTH]),
                            e[eb + SAMPLE_WIDTH], e[eb + SAMPLE_WIDTH + 1], even_c,
                            e[ob + SAMPLE_WIDTH], e[ob + SAMPLE_WIDTH + 1], odd_c);
   endfunction

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
         assign push_entry[c*SLOT_W +: SLOT_W] = {user_data_bit[c], valid_bit[c], audio_sample_word[c]};
         assign channel_status[c] = build_channel_status(CS_PARAMS, c);
      end
   endgenerate

   assign push               = audio_valid && audio_ready;
   assign pop_count          = packet_request ? pop_avail : 3'd0;
   assign frame_counter_next = frame_index_add(frame_counter, pop_avail);

   audio_frame_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .TAPS  (TAPS)
   ) u_fifo (
      .clk       (clk_packet),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_entry),
      .pop_count (pop_count),
      .ready     (audio_ready),
      .level     (fifo_level),
      .taps      (taps)
   );

   generate
      if (CHANNELS == 2) begin : g_layout_stereo
         always_comb begin
            logic [7:0] idx;
            idx       = 8'd0;
            pop_avail = (fifo_level >= LW'(4)) ? 3'd4 : 3'(fifo_level);
            present   = '0;
            b_flags   = '0;
            sub_next  = '0;
            for (int j = 0; j < 4; j++) begin
               idx = frame_index_add(frame_counter, 3'(j));
               if (3'(j) < pop_avail) begin
                  present[j]  = 1'b1;
                  b_flags[j]  = (idx == 8'd0);
                  sub_next[j] = build_sub(taps[j], 0, channel_status[0][idx], channel_status[1][idx]);
               end
            end
         end
      end else begin : g_layout_multi
         always_comb begin
            pop_avail  = {2'b00, (fifo_level != '0)};
            present    = '0;
            b_flags    = '0;
            sub_next   = '0;
            b_flags[0] = (frame_counter == 8'd0);
            for (int k = 0; k < CHANNELS / 2; k++) begin
               present[k]  = 1'b1;
               sub_next[k] = build_sub(taps[0], 2 * k, channel_status[2*k][frame_counter],
                                       channel_status[2*k+1][frame_counter]);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_packet) begin
      if (!reset_n) begin
         frame_counter <= 8'd0;
         packet_valid  <= 1'b0;
         header        <= 24'd0;
         sub           <= '0;
      end else begin
         packet_valid <= 1'b0;
         if (packet_request && (pop_avail != 3'd0)) begin
            packet_valid  <= 1'b1;
            frame_counter <= frame_counter_next;
            header        <= {b_flags, 4'b0000, 3'b000, LAYOUT, present, PKT_TYPE_AUDIO_SAMPLE};
            sub           <= sub_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_packet_multichannel.sv
// ============================================================================
// tb_audio_sample_packet_multichannel: scoreboard bench, stereo and 8-channel
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_sample_packet_multichannel;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_a_n, a_valid, a_ready, a_req, a_pv;
   logic [1:0][15:0] a_word;
   logic [1:0]       a_v, a_u;
   logic [23:0]      a_header;
   logic [3:0][55:0] a_sub;
   logic [2:0]       a_level;

   logic             rst_b_n, b_valid, b_ready, b_req, b_pv;
   logic [7:0][23:0] b_word;
   logic [7:0]       b_v, b_u;
   logic [23:0]      b_header;
   logic [3:0][55:0] b_sub;
   logic [4:0]       b_level;

   audio_sample_packet_multichannel #(.CHANNELS(2), .SAMPLE_WIDTH(16), .FIFO_DEPTH(4)) dut_a (
      .clk_packet(clk), .reset_n(rst_a_n), .audio_sample_word(a_word), .valid_bit(a_v),
      .user_data_bit(a_u), .audio_valid(a_valid), .audio_ready(a_ready), .packet_request(a_req),
      .packet_valid(a_pv), .header(a_header), .sub(a_sub), .fifo_level(a_level));

   audio_sample_packet_multichannel #(.CHANNELS(8), .SAMPLE_WIDTH(24), .FIFO_DEPTH(16)) dut_b (
      .clk_packet(clk), .reset_n(rst_b_n), .audio_sample_word(b_word), .valid_bit(b_v),
      .user_data_bit(b_u), .audio_valid(b_valid), .audio_ready(b_ready), .packet_request(b_req),
      .packet_valid(b_pv), .header(b_header), .sub(b_sub), .fifo_level(b_level));

   typedef struct { logic [7:0][23:0] s; logic [7:0] v; logic [7:0] u; } frame_t;
   typedef struct { logic [23:0] header; logic [3:0][55:0] sub; } pkt_t;

   frame_t mq_a[$], mq_b[$];
   pkt_t   eq_a[$], eq_b[$];
   pkt_t   last_a;
   int     fc_a, fc_b;
   bit     mrdy_a, mrdy_b;
   int     checks = 0, errors = 0, bcount_a = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Default stream parameters: copyright bit 1, word length 4'b1011, channel number = ch+1.
   function automatic bit cs_bit(int ch, int k);
      logic [3:0] num;
      logic [3:0] wl;
      num = 4'(ch + 1);
      wl  = 4'b1011;
      if (k == 2) return 1'b1;
      if (k >= 20 && k <= 23) return num[k-20];
      if (k >= 32 && k <= 35) return wl[k-32];
      return 1'b0;
   endfunction

   function automatic logic [55:0] exp_sub(logic [23:0] e, logic [23:0] o,
                                           bit ve, bit ue, bit ce, bit vo, bit uo, bit co);
      bit pe, po;
      pe = (^e) ^ ve ^ ue ^ ce;
      po = (^o) ^ vo ^ uo ^ co;
      return {po, co, uo, vo, pe, ce, ue, ve, o, e};
   endfunction

   function automatic frame_t rnd_frame();
      frame_t f;
      for (int c = 0; c < 8; c++) f.s[c] = 24'($urandom);
      f.v = 8'($urandom);
      f.u = 8'($urandom);
      return f;
   endfunction

   task automatic model_req_a();
      pkt_t p; frame_t f; int n, idx;
      n = (mq_a.size() < 4) ? mq_a.size() : 4;
      if (n == 0) return;
      p.header = 24'd2;
      p.sub    = '0;
      for (int j = 0; j < n; j++) begin
         f   = mq_a.pop_front();
         idx = (fc_a + j) % 192;
         p.header[8+j] = 1'b1;
         if (idx == 0) p.header[20+j] = 1'b1;
         p.sub[j] = exp_sub({f.s[0][15:0], 8'h00}, {f.s[1][15:0], 8'h00},
                            f.v[0], f.u[0], cs_bit(0, idx), f.v[1], f.u[1], cs_bit(1, idx));
      end
      fc_a = (fc_a + n) % 192;
      last_a = p;
      eq_a.push_back(p);
   endtask

   task automatic model_req_b();
      pkt_t p; frame_t f;
      if (mq_b.size() == 0) return;
      f = mq_b.pop_front();
      p.header = {3'b000, (fc_b == 0), 4'b0000, 8'h1F, 8'h02};
      for (int k = 0; k < 4; k++)
         p.sub[k] = exp_sub(f.s[2*k], f.s[2*k+1], f.v[2*k], f.u[2*k], cs_bit(2*k, fc_b),
                            f.v[2*k+1], f.u[2*k+1], cs_bit(2*k+1, fc_b));
      fc_b = (fc_b + 1) % 192;
      eq_b.push_back(p);
   endtask

   task automatic step_a(bit push, frame_t f, bit req);
      a_valid = push; a_req = req;
      a_word[0] = f.s[0][15:0]; a_word[1] = f.s[1][15:0];
      a_v = f.v[1:0]; a_u = f.u[1:0];
      if (req) model_req_a();
      if (push && mrdy_a) mq_a.push_back(f);
      @(posedge clk); #1;
      a_valid = 0; a_req = 0;
      mrdy_a = (mq_a.size() < 4);
   endtask

   task automatic step_b(bit push, frame_t f, bit req);
      b_valid = push; b_req = req;
      b_word = f.s; b_v = f.v; b_u = f.u;
      if (req) model_req_b();
      if (push && mrdy_b) mq_b.push_back(f);
      @(posedge clk); #1;
      b_valid = 0; b_req = 0;
      mrdy_b = (mq_b.size() < 16);
   endtask

   task automatic reset_a();
      rst_a_n = 0; a_valid = 0; a_req = 0;
      repeat (2) @(posedge clk);
      #1;
      mq_a.delete(); eq_a.delete(); fc_a = 0; mrdy_a = 0;
      check("a_rst_ready", a_ready, 0);
      check("a_rst_valid", a_pv, 0);
      check("a_rst_header", a_header, 0);
      check("a_rst_sub", a_sub, 0);
      check("a_rst_level", a_level, 0);
      rst_a_n = 1;
      @(posedge clk); #1;
      mrdy_a = 1;
      check("a_ready_after_rst", a_ready, 1);
   endtask

   task automatic reset_b();
      rst_b_n = 0; b_valid = 0; b_req = 0;
      repeat (2) @(posedge clk);
      #1;
      mq_b.delete(); eq_b.delete(); fc_b = 0; mrdy_b = 0;
      check("b_rst_ready", b_ready, 0);
      check("b_rst_header", b_header, 0);
      check("b_rst_sub", b_sub, 0);
      rst_b_n = 1;
      @(posedge clk); #1;
      mrdy_b = 1;
      check("b_ready_after_rst", b_ready, 1);
   endtask

   task automatic drain();
      @(negedge clk); #1;
      check("a_packets_pending", eq_a.size(), 0);
      check("b_packets_pending", eq_b.size(), 0);
   endtask

   always @(negedge clk) begin
      pkt_t p;
      if (a_pv === 1'b1) begin
         bcount_a += $countones(a_header[23:20]);
         if (eq_a.size() == 0) check("a_unexpected_packet", a_pv, 0);
         else begin
            p = eq_a.pop_front();
            check("a_header", a_header, p.header);
            check("a_sub", a_sub, p.sub);
         end
      end
      if (b_pv === 1'b1) begin
         if (eq_b.size() == 0) check("b_unexpected_packet", b_pv, 0);
         else begin
            p = eq_b.pop_front();
            check("b_header", b_header, p.header);
            check("b_sub", b_sub, p.sub);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f;
      int     sent, cyc;
      bit     p, r;
      a_word = '0; a_v = '0; a_u = '0; a_valid = 0; a_req = 0;
      b_word = '0; b_v = '0; b_u = '0; b_valid = 0; b_req = 0;
      rst_a_n = 0; rst_b_n = 0;
      reset_a();
      reset_b();

      // Fill the 4-deep FIFO; the fifth offer is refused.
      for (int i = 0; i < 5; i++) step_a(1, rnd_frame(), 0);
      check("a_full_level", a_level, 4);
      check("a_full_ready", a_ready, 0);
      step_a(1, rnd_frame(), 1);
      check("a_hb1_four", a_header[15:8], 8'h0F);
      check("a_level_after_pop4", a_level, 0);
      check("a_ready_returns", a_ready, 1);
      drain();

      // Single 16-bit frame is left-justified.
      f = rnd_frame();
      f.s[0] = 24'h00ABCD;
      step_a(1, f, 0);
      step_a(0, f, 1);
      check("a_hb1_single", a_header[15:8], 8'h01);
      check("a_sub_upper_zero", a_sub[3:1], 0);
      check("a_justify", a_sub[0][23:0], 24'hABCD00);
      check("a_level_single", a_level, 0);
      drain();

      // Empty request: no packet, outputs hold.
      step_a(0, f, 1);
      check("a_empty_no_valid", a_pv, 0);
      check("a_empty_header_hold", a_header, last_a.header);
      check("a_empty_sub_hold", a_sub, last_a.sub);
      drain();

      // Partial packet, then request while packet_valid is high.
      for (int i = 0; i < 3; i++) step_a(1, rnd_frame(), 0);
      step_a(1, rnd_frame(), 1);
      step_a(0, f, 1);
      check("a_level_b2b", a_level, 0);
      drain();

      // Reset mid-stream discards buffered frames and restarts the frame counter.
      step_a(1, rnd_frame(), 0);
      step_a(1, rnd_frame(), 0);
      reset_a();
      step_a(1, rnd_frame(), 0);
      step_a(0, f, 1);
      check("a_b0_after_reset", a_header[23:20], 4'b0001);
      check("a_level_after_reset", a_level, 0);
      drain();

      // 400-frame stream: exactly three B flags (frames 0, 192, 384).
      reset_a();
      bcount_a = 0;
      sent = 0;
      cyc  = 0;
      while ((sent < 400 || mq_a.size() > 0) && cyc < 3000) begin
         p = (sent < 400) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) == 0);
         if (p && mrdy_a) sent++;
         step_a(p, rnd_frame(), r);
         cyc++;
      end
      check("a_stream_level", a_level, 0);
      drain();
      check("a_stream_b_count", bcount_a, 3);

      // Eight channels: one frame per packet, channel n carries n << 4.
      for (int c = 0; c < 8; c++) f.s[c] = 24'(c << 4);
      f.v = 8'h5A; f.u = 8'hC3;
      step_b(1, f, 0);
      check("b_level_one", b_level, 1);
      step_b(0, f, 1);
      check("b_hb1", b_header[15:8], 8'h1F);
      check("b_hb0", b_header[7:0], 8'h02);
      check("b_b0_first", b_header[23:20], 4'b0001);
      check("b_sub3_odd", b_sub[3][47:24], 24'h000070);
      check("b_sub1_even", b_sub[1][23:0], 24'h000020);
      check("b_level_zero", b_level, 0);
      drain();

      for (int i = 0; i < 3; i++) step_b(1, rnd_frame(), 0);
      for (int i = 0; i < 3; i++) step_b(0, f, 1);
      check("b_level_b2b", b_level, 0);
      drain();

      // Carry past status bits 20..23 so every channel number is exercised.
      for (int i = 0; i < 30; i++) step_b(1, rnd_frame(), 1);
      step_b(0, f, 1);
      check("b_level_stream", b_level, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
